fulladdr_bist: RTL and testbench
================================

# fulladdr_bist

Sequential built-in self-test controller for the 1-bit full adder in the data-flow library. It drives all eight `{a,b,ci}` input combinations into the adder under test, waits a settle interval, and samples `{c,s}`. It compares the sample against the arithmetic sum and reports a pass/fail verdict, a mismatch count and a per-pattern failure map. It sits between system control and one full-adder instance: its outputs connect to the adder inputs, and the adder outputs return to it.

## Interface
- `ROUNDS`, default 1: number of full 8-pattern sweeps per run. Legal range 1..15.
- `SETTLE`, default 2: cycles each pattern is held before sampling. Legal range 1..15.
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: run request. Sampled only in IDLE.
- `a` out 1: adder operand a. Registered.
- `b` out 1: adder operand b. Registered.
- `ci` out 1: adder carry-in. Registered.
- `s` in 1: adder sum output under test.
- `c` in 1: adder carry output under test.
- `busy` out 1: high from the cycle after start is accepted until done.
- `done` out 1: one-cycle pulse at the end of a run.
- `pass` out 1: verdict. Valid from done until the next accepted start.
- `err_count` out 8: mismatches in the current or last run. Saturates at 255.
- `fail_vec` out 8: bit i is set if pattern i (`{a,b,ci}`=i) mismatched in any round.

## Operation
- State machine states:
  - IDLE: `busy`=0. `start`=1 → DRIVE. At this transition `pattern`←0, `round`←0, `err_count`←0, `fail_vec`←0, `pass`←0, and the settle counter←0.
  - DRIVE: `{a,b,ci}`=`pattern`. The settle counter increments each cycle. When it reaches SETTLE-1 → SAMPLE.
  - SAMPLE: compare `{c,s}` against `a+b+ci`, zero-extended to 2 bits.
    - On mismatch: `err_count`+1 (saturating) and `fail_vec[pattern]`←1.
    - If `pattern`==7 and `round`==ROUNDS-1 → DONE.
    - Else if `pattern`==7: `pattern` wraps to 0, `round`+1, → DRIVE.
    - Else: `pattern`+1 → DRIVE.
    - The settle counter is cleared on every transition out of SAMPLE.
  - DONE: `done`=1 for one cycle. `pass`←(`err_count`==0, including any update made in the final SAMPLE). → IDLE.
- `start` is ignored in DRIVE, SAMPLE and DONE. There is no queuing.
- `err_count`, `fail_vec` and `pass` hold their values in IDLE until the next accepted start.
- `{a,b,ci}` hold the last pattern value while in IDLE and DONE.

## Timing
- Reset values: `a`=`b`=`ci`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=0, state IDLE, all counters 0.
- `rst` mid-run aborts immediately, returns all outputs to reset values on the next edge, and produces no `done` pulse.
- Edge E0 is the edge at which `start` is seen high in IDLE. At E0+1, `busy`=1 and pattern 0 is on `{a,b,ci}`.
- Each pattern occupies exactly SETTLE+1 cycles: SETTLE in DRIVE plus 1 in SAMPLE.
- `s` and `c` are sampled at the end of the SAMPLE cycle. The adder under test must settle within SETTLE+1 cycles.
- `done` is high during the cycle starting at E0 + 8·ROUNDS·(SETTLE+1) + 1. `busy` is low in that same cycle.
- Earliest restart: `start` seen at the edge that ends DONE is ignored. `start` seen at the next edge (in IDLE) is accepted.

## Configuration
- `FULLADDR_BIST_STOP_ON_FAIL_EN`
  - Defined: the first mismatch in SAMPLE goes directly to DONE, regardless of pattern or round. `err_count`=1 and `fail_vec` has exactly one bit set.
  - Undefined: every run completes all 8·ROUNDS patterns. This is the default.

## Test plan
- Correct behavioral adder, ROUNDS=2, SETTLE=2 → `done` 48 cycles after `busy` rises, `pass`=1, `err_count`=0, `fail_vec`=8'h00.
- `s` stuck at 0, ROUNDS=2 → `pass`=0, `err_count`=8, `fail_vec`=8'b1001_0110 (patterns 1,2,4,7).
- `c` stuck at 1, ROUNDS=1 → `err_count`=4, `fail_vec`=8'b0001_0111.
- `start` pulsed again mid-run → no restart. Only one `done` pulse occurs, at the original completion time.
- `rst` asserted while running at pattern 5 → next cycle all outputs are 0 and the state is IDLE. A following `start` gives a full run with correct results.
- Macro defined, `s` stuck at 0 → `done` after pattern 1's SAMPLE, `err_count`=1, `fail_vec`=8'b0000_0010.

Source files
------------

// File: rtl/fulladdr_bist.sv
// Built-in self-test controller for a 1-bit full adder: sweeps all {a,b,ci} patterns, checks {c,s}.
// Optional: define FULLADDR_BIST_STOP_ON_FAIL_EN to end the run at the first mismatch.
module fulladdr_bist #(
    parameter int ROUNDS = 1,
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       ci,
    input  logic       s,
    input  logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [7:0] fail_vec,
    output logic [1:0] dbg_state
);

    // Handshake: start is a level request, accepted only in IDLE on a rising edge;
    // done is a one-cycle pulse and pass/err_count/fail_vec are valid from done until the next accept.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0] ROUND_LAST  = 4'(ROUNDS - 1);

    state_t     state;
    state_t     state_next;
    logic [2:0] pattern;
    logic [3:0] round;
    logic [3:0] settle_cnt;
    logic [1:0] expected;
    logic       mismatch;
    logic [7:0] err_next;
    logic       last_pattern;
    logic       last_round;

    // The pattern register drives the adder directly, so the operands are registered outputs.
    assign {a, b, ci}   = pattern;
    assign busy         = (state == DRIVE) || (state == SAMPLE);
    assign done         = (state == DONE);
    assign dbg_state    = state;
    assign last_pattern = (pattern == 3'd7);
    assign last_round   = (round == ROUND_LAST);

    always_comb begin
        expected = {1'b0, a} + {1'b0, b} + {1'b0, ci};
        mismatch = (state == SAMPLE) && ({c, s} != expected);
        err_next = err_count;
        if (mismatch && (err_count != 8'hFF)) begin
            err_next = err_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                if (last_pattern && last_round) begin
                    state_next = DONE;
                end else begin
                    state_next = DRIVE;
                end
`ifdef FULLADDR_BIST_STOP_ON_FAIL_EN
                if (mismatch) begin
                    state_next = DONE;
                end
`endif
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern    <= 3'd0;
            round      <= 4'd0;
            settle_cnt <= 4'd0;
            err_count  <= 8'd0;
            fail_vec   <= 8'd0;
            pass       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pattern    <= 3'd0;
                        round      <= 4'd0;
                        settle_cnt <= 4'd0;
                        err_count  <= 8'd0;
                        fail_vec   <= 8'd0;
                        pass       <= 1'b0;
                    end
                end
                DRIVE: begin
                    settle_cnt <= settle_cnt + 4'd1;
                end
                SAMPLE: begin
                    err_count  <= err_next;
                    settle_cnt <= 4'd0;
                    if (mismatch) begin
                        fail_vec[pattern] <= 1'b1;
                    end
                    // The verdict is latched on entry to DONE so it is already valid during the done pulse.
                    if (state_next == DONE) begin
                        pass <= (err_next == 8'd0);
                    end else if (last_pattern) begin
                        pattern <= 3'd0;
                        round   <= round + 4'd1;
                    end else begin
                        pattern <= pattern + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fulladdr_bist.sv
// Directed bench for fulladdr_bist (ROUNDS=2, SETTLE=2) with a fault-injectable full-adder model.
module tb_fulladdr_bist;

  localparam int ROUNDS = 2;
  localparam int SETTLE = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;

  logic       clk;
  logic       rst;
  logic       start;
  logic       a, b, ci;
  logic       s, c;
  logic       busy, done, pass;
  logic [7:0] err_count, fail_vec;
  logic [1:0] dbg_state;

  int tests_run;
  int tests_failed;
  int fault;  // 0: good adder, 1: s stuck at 0, 2: c stuck at 1
  logic [1:0] true_sum;

  fulladdr_bist #(.ROUNDS(ROUNDS), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .ci(ci), .s(s), .c(c),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // adder under test
  always_comb begin
    true_sum = {1'b0, a} + {1'b0, b} + {1'b0, ci};
    s = (fault == 1) ? 1'b0 : true_sum[0];
    c = (fault == 2) ? 1'b1 : true_sum[1];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns at the falling edge inside cycle E0+1.
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // n = cycle index after E0 at which done is seen (E0+1 is n=1); poke re-asserts start mid-run.
  task automatic wait_done(input int poke, output int n);
    n = 1;
    while (!done && n < 300) begin
      start = (n == poke);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_abc"}, {29'd0, a, b, ci}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_pass"}, {31'd0, pass}, 32'd0);
    check({tag, "_err"}, {24'd0, err_count}, 32'd0);
    check({tag, "_fail"}, {24'd0, fail_vec}, 32'd0);
    check({tag, "_state"}, {30'd0, dbg_state}, {30'd0, ST_IDLE});
  endtask

  initial begin
    int n;
    int pulses;
    int guard;
    tests_run = 0;
    tests_failed = 0;
    fault = 0;
    start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Good adder, with a second start mid-run that must be ignored.
    pulse_start();
    check("good_busy_rise", {31'd0, busy}, 32'd1);
    check("good_pat0", {29'd0, a, b, ci}, 32'd0);
    wait_done(10, n);
    check("good_done_time", n, 49);
    check("good_busy_at_done", {31'd0, busy}, 32'd0);
    check("good_pass", {31'd0, pass}, 32'd1);
    check("good_err", {24'd0, err_count}, 32'd0);
    check("good_fail", {24'd0, fail_vec}, 32'h00);
    check("good_hold_abc", {29'd0, a, b, ci}, 32'd7);
    count_done(20, pulses);
    check("good_single_done", pulses, 0);
    check("good_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check("good_pass_hold", {31'd0, pass}, 32'd1);

    // s stuck at 0: fails on patterns 1,2,4,7 each round.
    fault = 1;
    pulse_start();
    check("s0_pass_clr", {31'd0, pass}, 32'd0);
    check("s0_err_clr", {24'd0, err_count}, 32'd0);
    wait_done(-1, n);
`ifdef FULLADDR_BIST_STOP_ON_FAIL_EN
    check("s0_done_time", n, 7);
    check("s0_err", {24'd0, err_count}, 32'd1);
    check("s0_fail", {24'd0, fail_vec}, 32'h02);
`else
    check("s0_done_time", n, 49);
    check("s0_err", {24'd0, err_count}, 32'd8);
    check("s0_fail", {24'd0, fail_vec}, 32'h96);
`endif
    check("s0_pass", {31'd0, pass}, 32'd0);
    repeat (4) @(negedge clk);
`ifdef FULLADDR_BIST_STOP_ON_FAIL_EN
    check("s0_err_hold", {24'd0, err_count}, 32'd1);
`else
    check("s0_err_hold", {24'd0, err_count}, 32'd8);
`endif

    // c stuck at 1: fails on patterns 0,1,2,4 each round.
    fault = 2;
    pulse_start();
    check("c1_fail_clr", {24'd0, fail_vec}, 32'd0);
    wait_done(-1, n);
`ifdef FULLADDR_BIST_STOP_ON_FAIL_EN
    check("c1_done_time", n, 4);
    check("c1_err", {24'd0, err_count}, 32'd1);
    check("c1_fail", {24'd0, fail_vec}, 32'h01);
`else
    check("c1_done_time", n, 49);
    check("c1_err", {24'd0, err_count}, 32'd8);
    check("c1_fail", {24'd0, fail_vec}, 32'h17);
`endif
    check("c1_pass", {31'd0, pass}, 32'd0);

    // Reset while pattern 5 is being driven.
    fault = 0;
    pulse_start();
    guard = 0;
    while ({a, b, ci} != 3'd5 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("rst_reach_p5", {29'd0, a, b, ci}, 32'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midrst");
    count_done(60, pulses);
    check("midrst_no_done", pulses, 0);

    // Full run after the abort, then earliest-restart timing.
    pulse_start();
    check("post_busy", {31'd0, busy}, 32'd1);
    wait_done(-1, n);
    check("post_done_time", n, 49);
    check("post_pass", {31'd0, pass}, 32'd1);
    check("post_fail", {24'd0, fail_vec}, 32'h00);
    start = 1'b1;
    @(negedge clk);
    check("restart_ignored_busy", {31'd0, busy}, 32'd0);
    check("restart_ignored_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    @(negedge clk);
    start = 1'b0;
    check("restart_busy", {31'd0, busy}, 32'd1);
    check("restart_state", {30'd0, dbg_state}, {30'd0, ST_DRIVE});
    check("restart_pat0", {29'd0, a, b, ci}, 32'd0);
    wait_done(-1, n);
    check("restart_done_time", n, 49);
    check("restart_pass", {31'd0, pass}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
